dcache_dm: RTL
==============

// Module: dcache_dm
// PURPOSE
//  Parametrised direct-mapped, write-through, no-write-allocate L1 data cache for the MEM stage.
//  Sits between the core's load/store port and a word-wide backing-memory bus.
//  Supports byte-enable stores, multi-word line refill and a whole-cache invalidate.
//  Read hits are 1-cycle pipelined; misses and stores stall the core via req_ready.
// PARAMETERS
//  LINES       64  number of cache lines, power of two >= 2
//  LINE_WORDS  4   32-bit words per line, power of two >= 1
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   synchronous, active-high reset
//  flush           in   1   invalidate all lines; honoured only in IDLE
//  req_valid       in   1   core request valid
//  req_we          in   1   1 = store, 0 = load
//  req_addr        in   32  byte address; [1:0] ignored
//  req_be          in   4   store byte enables; ignored for loads
//  req_wdata       in   32  store data
//  req_ready       out  1   request accepted when req_valid && req_ready
//  resp_valid      out  1   load data valid, 1-cycle pulse
//  resp_rdata      out  32  load data
//  mem_req_valid   out  1   backing-memory request
//  mem_req_we      out  1   1 = word write, 0 = word read
//  mem_req_addr    out  32  word-aligned address
//  mem_req_be      out  4   write byte enables
//  mem_req_wdata   out  32  write data
//  mem_req_ready   in   1   memory accepts request this cycle
//  mem_resp_valid  in   1   read data return; at most one outstanding read
//  mem_resp_rdata  in   32  read data
// BEHAVIOUR
//  Address split: [1:0] byte, [2 +: WOFF] word, [2+WOFF +: IDX] index, rest = tag.
//    WOFF = log2(LINE_WORDS), IDX = log2(LINES).
//  Reset: state IDLE; all valid bits 0; req_ready 1; resp_valid 0; resp_rdata 0.
//    Also at reset: mem_req_valid 0, mem_req_we 0; tag/data arrays not reset.
//  States: IDLE, REFILL_REQ, REFILL_WAIT, WRITE_THRU.
//  IDLE: req_ready = !flush.
//    Load hit accepted in cycle N -> resp_valid=1 with word in N+1; back-to-back hits at 1/cycle.
//    Load miss -> REFILL_REQ, word counter = 0, req_ready=0.
//    Store accepted -> on hit, byte-merge req_wdata into the line at the edge; latch request -> WRITE_THRU.
//      On miss, the array is unchanged.
//    flush=1 in IDLE: all valid bits cleared next edge; a concurrent req_valid is not accepted.
//  REFILL_REQ: mem_req_valid=1, we=0, addr = {tag,idx,cnt,2'b00}.
//    Held stable until mem_req_ready -> REFILL_WAIT.
//  REFILL_WAIT: on mem_resp_valid, write word cnt into the line.
//    If cnt != LINE_WORDS-1: cnt++ -> REFILL_REQ.
//    On the last word: write tag, set valid -> IDLE.
//      Next cycle: resp_valid=1 with the requested word; req_ready=1 that cycle.
//  WRITE_THRU: mem_req_valid=1, we=1, be/wdata/addr latched and stable until mem_req_ready -> IDLE.
//    Stores produce no resp_valid.
//  mem_resp_valid outside REFILL_WAIT is ignored.
//  Valid bit of a refilling line is cleared on REFILL_REQ entry; rst mid-refill leaves it invalid.
//  rst in any state: abort immediately; outstanding memory transaction is dropped (bus is also reset).
//  req_* inputs sampled only on acceptance; changes while req_ready=0 are ignored.
// STRUCTURE
//  dcache_pkg: state enum, DCACHE_WORD_W=32, localparam functions for WOFF/IDX/TAG widths.
//  Sub-module dcache_data_ram: LINES*LINE_WORDS x 32 RAM, async read, per-byte write enable.
//  Tag array, valid vector and FSM stay in dcache_dm.
// TESTING
//  1. Reset, load 0x100 -> 4 mem reads 0x100..0x10C, 1 outstanding; resp_rdata = word @0x100; valid set.
//  2. Loads 0x104,0x108,0x10C back-to-back after 1 -> 3 resp_valid pulses on consecutive cycles, no mem reqs.
//  3. Store be=4'b0010 wdata=0xAABBCCDD to 0x104 (hit) -> mem write issued; reload 0x104 -> byte1=0xCC, others old.
//  4. Store to miss 0x2000 -> mem write only; subsequent load 0x2000 triggers refill (no allocate).
//  5. LINES=64, LINE_WORDS=4: load 0x100 then 0x1100 (same index) -> second refills, evicting; 0x100 misses again.
//  6. rst during REFILL_WAIT, then flush with req_valid=1 -> IDLE, ready=0 during flush, all loads miss afterwards.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped L1 data cache.
package dcache_pkg;

  localparam int DCACHE_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_REFILL_REQ  = 2'd1,
    ST_REFILL_WAIT = 2'd2,
    ST_WRITE_THRU  = 2'd3
  } dcache_state_e;

  // Ceiling log2; sizes here are powers of two, so this is exact.
  function automatic int dcache_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int dcache_woff_w(input int line_words);
    return dcache_log2(line_words);
  endfunction

  function automatic int dcache_idx_w(input int lines);
    return dcache_log2(lines);
  endfunction

  function automatic int dcache_tag_w(input int lines, input int line_words);
    return DCACHE_WORD_W - 2 - dcache_log2(line_words) - dcache_log2(lines);
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Data array of the cache: one 32-bit word per entry, asynchronous read,
// per-byte write enables so store hits can merge partial words.
module dcache_data_ram
  import dcache_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                     clk,
  input  logic [AW-1:0]            addr,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [DCACHE_WORD_W-1:0] wdata,
  output logic [DCACHE_WORD_W-1:0] rdata
);

  logic [DCACHE_WORD_W-1:0] mem [DEPTH];

  // Byte-granular write; contents are never reset, validity lives in the tag side.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
//
// state          | meaning
// ST_IDLE        | accepting core requests; load hits answered next cycle
// ST_REFILL_REQ  | presenting a line-refill word read to memory
// ST_REFILL_WAIT | waiting for that read's data, writing it into the line
// ST_WRITE_THRU  | presenting the latched store to memory
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [DCACHE_WORD_W-1:0] req_addr,
  input  logic [3:0]               req_be,
  input  logic [DCACHE_WORD_W-1:0] req_wdata,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [DCACHE_WORD_W-1:0] resp_rdata,
  output logic                     mem_req_valid,
  output logic                     mem_req_we,
  output logic [DCACHE_WORD_W-1:0] mem_req_addr,
  output logic [3:0]               mem_req_be,
  output logic [DCACHE_WORD_W-1:0] mem_req_wdata,
  input  logic                     mem_req_ready,
  input  logic                     mem_resp_valid,
  input  logic [DCACHE_WORD_W-1:0] mem_resp_rdata
);

  localparam int WOFF  = dcache_woff_w(LINE_WORDS);
  localparam int IDX   = dcache_idx_w(LINES);
  localparam int TAG_W = dcache_tag_w(LINES, LINE_WORDS);
  localparam int CNT_W = (WOFF > 0) ? WOFF : 1;
  localparam int DEPTH = LINES * LINE_WORDS;
  localparam int AW    = dcache_log2(DEPTH);
  localparam logic [31:0]      LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [31:0]      WORD_MASK = 32'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LINE_WORDS - 1);

  dcache_state_e state_q, state_d;

  logic [CNT_W-1:0]         cnt_q;
  logic [LINES-1:0]         valid_q;
  logic [TAG_W-1:0]         tag_mem [LINES];
  logic [DCACHE_WORD_W-1:0] lat_addr, lat_wdata, refill_word_q;
  logic [3:0]               lat_be;

  logic [IDX-1:0]   req_idx, lat_idx;
  logic [TAG_W-1:0] req_tag, lat_tag;
  logic [CNT_W-1:0] req_word, lat_word;
  logic             hit, accept, last_word;

  logic [AW-1:0]            ram_addr;
  logic                     ram_we;
  logic [3:0]               ram_be;
  logic [DCACHE_WORD_W-1:0] ram_wdata, ram_rdata;

  // WOFF may be zero, so fields are extracted by shift and mask rather than slices.
  assign req_word = CNT_W'((req_addr >> 2) & WORD_MASK);
  assign req_idx  = IDX'(req_addr >> (2 + WOFF));
  assign req_tag  = TAG_W'(req_addr >> (2 + WOFF + IDX));
  assign lat_word = CNT_W'((lat_addr >> 2) & WORD_MASK);
  assign lat_idx  = IDX'(lat_addr >> (2 + WOFF));
  assign lat_tag  = TAG_W'(lat_addr >> (2 + WOFF + IDX));

  assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept    = req_valid && req_ready;
  assign last_word = (cnt_q == CNT_LAST);

  function automatic logic [AW-1:0] ram_ix(input logic [IDX-1:0] i, input logic [CNT_W-1:0] w);
    return (AW'(i) << WOFF) | AW'(w);
  endfunction

  assign mem_req_addr  = mem_req_we ? {lat_addr[31:2], 2'b00}
                                    : ((lat_addr & ~LINE_MASK) | (32'(cnt_q) << 2));
  assign mem_req_be    = mem_req_we ? lat_be : 4'hf;
  assign mem_req_wdata = lat_wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) begin
          if (req_we)   state_d = ST_WRITE_THRU;
          else if (!hit) state_d = ST_REFILL_REQ;
        end
      end
      ST_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_REFILL_WAIT;
      end
      ST_REFILL_WAIT: begin
        if (mem_resp_valid) state_d = last_word ? ST_IDLE : ST_REFILL_REQ;
      end
      ST_WRITE_THRU: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        if (mem_req_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single data-array port: refill writes in REFILL_WAIT, lookups and store merges otherwise.
  always_comb begin
    ram_addr  = ram_ix(req_idx, req_word);
    ram_we    = 1'b0;
    ram_be    = req_be;
    ram_wdata = req_wdata;
    if (state_q == ST_REFILL_WAIT) begin
      ram_addr  = ram_ix(lat_idx, cnt_q);
      ram_we    = mem_resp_valid;
      ram_be    = 4'hf;
      ram_wdata = mem_resp_rdata;
    end else if (state_q == ST_IDLE) begin
      ram_we = accept && req_we && hit;
    end
  end

  dcache_data_ram #(.DEPTH(DEPTH), .AW(AW)) u_data_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Valid bits, refill counter, request latch and load response.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      cnt_q         <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      lat_addr      <= '0;
      lat_be        <= '0;
      lat_wdata     <= '0;
      refill_word_q <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (accept) begin
            lat_addr  <= req_addr;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
            if (!req_we) begin
              if (hit) begin
                resp_valid <= 1'b1;
                resp_rdata <= ram_rdata;
              end else begin
                // Line is invalid until its last word lands, so an aborted refill never hits.
                valid_q[req_idx] <= 1'b0;
                cnt_q            <= '0;
              end
            end
          end
        end
        ST_REFILL_WAIT: begin
          if (mem_resp_valid) begin
            if (cnt_q == lat_word) refill_word_q <= mem_resp_rdata;
            if (last_word) begin
              valid_q[lat_idx] <= 1'b1;
              resp_valid       <= 1'b1;
              resp_rdata       <= (cnt_q == lat_word) ? mem_resp_rdata : refill_word_q;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tag written together with the last refill word; the tag array is never reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_REFILL_WAIT && mem_resp_valid && last_word) tag_mem[lat_idx] <= lat_tag;
  end

endmodule
